// File: rtl/vga_text_console_ctrl.sv
// Write-side controller for the 80x30 text buffer: turns a byte stream into
// registered single-cycle character writes, tracks the cursor and sweeps full-screen clears.
module vga_text_console_ctrl #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  localparam int         AW         = $clog2(COLS*ROWS),
  localparam int         XW         = $clog2(COLS),
  localparam int         YW         = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    data_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          clear_i,
  output logic [7:0]    char_o,
  output logic [AW-1:0] addr_o,
  output logic          wen_o,
  output logic [XW-1:0] cursor_x_o,
  output logic [YW-1:0] cursor_y_o,
  output logic          busy_o
);

  // Handshake: a byte is consumed on a rising edge where valid_i && ready_o;
  // ready_o depends only on state_q and clear_i, never on valid_i.
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  logic [AW-1:0] cnt_q,   cnt_d;
  logic [7:0]    char_q,  char_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic          wen_q,   wen_d;
  logic          busy_q,  busy_d;

  logic [AW-1:0] lin_addr;
  logic [YW-1:0] next_row;

  assign ready_o    = (state_q == ST_IDLE) && !clear_i;
  assign char_o     = char_q;
  assign addr_o     = addr_q;
  assign wen_o      = wen_q;
  assign busy_o     = busy_q;
  assign cursor_x_o = cur_x_q;
  assign cursor_y_o = cur_y_q;

  // Largest product is (ROWS-1)*COLS+COLS-1, which fits AW bits by construction.
  assign lin_addr = AW'(cur_y_q) * AW'(COLS) + AW'(cur_x_q);
  assign next_row = (cur_y_q == YW'(ROWS-1)) ? '0 : cur_y_q + YW'(1);

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    addr_d  = addr_q;
    wen_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (valid_i) begin
          if (data_i >= 8'h20) begin
            wen_d  = 1'b1;
            char_d = data_i;
            addr_d = lin_addr;
            if (cur_x_q == XW'(COLS-1)) begin
              cur_x_d = '0;
              cur_y_d = next_row;
            end else begin
              cur_x_d = cur_x_q + XW'(1);
            end
          end else begin
            case (data_i)
              8'h0A: begin
                cur_x_d = '0;
                cur_y_d = next_row;
              end
              8'h0D: cur_x_d = '0;
              8'h08: begin
                if (cur_x_q != '0) begin
                  cur_x_d = cur_x_q - XW'(1);
                  wen_d   = 1'b1;
                  char_d  = BLANK_CHAR;
                  addr_d  = lin_addr - AW'(1);
                end
              end
              8'h0C: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        wen_d  = 1'b1;
        char_d = BLANK_CHAR;
        addr_d = cnt_q;
        if (cnt_q == AW'(COLS*ROWS-1)) begin
          state_d = ST_IDLE;
          cur_x_d = '0;
          cur_y_d = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_vga_text_console_ctrl.sv
// Directed bench for vga_text_console_ctrl: text writes, cursor wrap,
// control codes, clear sweeps and reset during a sweep.
module tb_vga_text_console_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic        clear_i;
  logic [7:0]  char_o;
  logic [11:0] addr_o;
  logic        wen_o;
  logic [6:0]  cursor_x_o;
  logic [4:0]  cursor_y_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  vga_text_console_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .clear_i    (clear_i),
    .char_o     (char_o),
    .addr_o     (addr_o),
    .wen_o      (wen_o),
    .cursor_x_o (cursor_x_o),
    .cursor_y_o (cursor_y_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    data_i  = b;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic check_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(cursor_x_o), x);
    check({tag, "_y"}, 32'(cursor_y_o), y);
  endtask

  initial begin
    int bad;
    int n;
    bit found;
    rst = 1'b1; data_i = 8'h00; valid_i = 1'b0; clear_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_wen", 32'(wen_o), 0);
    check("rst_char", 32'(char_o), 0);
    check("rst_addr", 32'(addr_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ready", 32'(ready_o), 1);
    check_cursor("rst_cur", 0, 0);

    // 'H','i' back-to-back
    send(8'h48);
    check("h_wen", 32'(wen_o), 1);
    check("h_char", 32'(char_o), 32'h48);
    check("h_addr", 32'(addr_o), 0);
    send(8'h69);
    check("i_wen", 32'(wen_o), 1);
    check("i_char", 32'(char_o), 32'h69);
    check("i_addr", 32'(addr_o), 1);
    check_cursor("hi_cur", 2, 0);
    tick();
    check("hi_wen_off", 32'(wen_o), 0);

    // End-of-row wrap, then vertical wrap via LF
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (79) send(8'h41);
    check("a79_addr", 32'(addr_o), 78);
    check_cursor("a79_cur", 79, 0);
    send(8'h42);
    check("b_wen", 32'(wen_o), 1);
    check("b_char", 32'(char_o), 32'h42);
    check("b_addr", 32'(addr_o), 79);
    check_cursor("b_cur", 0, 1);
    repeat (28) send(8'h0A);
    check_cursor("lf28_cur", 0, 29);
    send(8'h0A);
    check("lfwrap_wen", 32'(wen_o), 0);
    check_cursor("lfwrap_cur", 0, 0);

    // Backspace, CR, and BS at column 0
    repeat (3) send(8'h0A);
    repeat (5) send(8'h78);
    check_cursor("pos53", 5, 3);
    send(8'h08);
    check("bs_wen", 32'(wen_o), 1);
    check("bs_char", 32'(char_o), 32'h20);
    check("bs_addr", 32'(addr_o), 244);
    check_cursor("bs_cur", 4, 3);
    send(8'h0D);
    check("cr_wen", 32'(wen_o), 0);
    check_cursor("cr_cur", 0, 3);
    send(8'h08);
    check("bs0_wen", 32'(wen_o), 0);
    check_cursor("bs0_cur", 0, 3);

    // Form feed sweep with a byte held pending the whole time
    send(8'h0C);
    check("ff_busy", 32'(busy_o), 1);
    check("ff_wen", 32'(wen_o), 0);
    data_i = 8'h51; valid_i = 1'b1;
    #1;
    check("ff_ready", 32'(ready_o), 0);
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      tick();
      if (!(wen_o === 1'b1 && addr_o === 12'(i) && char_o === 8'h20)) bad++;
      if (i < 2399 && (busy_o !== 1'b1 || ready_o !== 1'b0)) bad++;
    end
    check("ff_sweep_bad", bad, 0);
    check("ff_end_busy", 32'(busy_o), 0);
    check("ff_end_ready", 32'(ready_o), 1);
    check_cursor("ff_end_cur", 0, 0);
    tick();
    valid_i = 1'b0;
    check("held_wen", 32'(wen_o), 1);
    check("held_char", 32'(char_o), 32'h51);
    check("held_addr", 32'(addr_o), 0);
    check_cursor("held_cur", 1, 0);

    // clear_i wins over valid_i; re-pulse mid-sweep does not restart
    data_i = 8'h5A; valid_i = 1'b1; clear_i = 1'b1;
    #1;
    check("clr_ready", 32'(ready_o), 0);
    tick();
    valid_i = 1'b0; clear_i = 1'b0;
    check("clr_busy", 32'(busy_o), 1);
    check("clr_wen", 32'(wen_o), 0);
    check_cursor("clr_cur", 1, 0);
    n = 0; bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      clear_i = (cyc == 500);
      if (wen_o === 1'b1) begin
        if (addr_o !== 12'(n) || char_o !== 8'h20) bad++;
        n++;
      end
      if (busy_o !== 1'b1) break;
    end
    clear_i = 1'b0;
    check("clr_count", n, 2400);
    check("clr_sweep_bad", bad, 0);
    check("clr_end_busy", 32'(busy_o), 0);
    tick();
    check("clr_no_z", 32'(wen_o), 0);
    check_cursor("clr_end_cur", 0, 0);

    // Reset in the middle of a sweep, then BEL
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (wen_o === 1'b1 && addr_o === 12'd1000) begin
        found = 1'b1;
        break;
      end
    end
    check("sweep_1000_seen", 32'(found), 1);
    rst = 1'b1;
    tick();
    check("mrst_wen", 32'(wen_o), 0);
    check("mrst_busy", 32'(busy_o), 0);
    check("mrst_ready", 32'(ready_o), 1);
    check("mrst_addr", 32'(addr_o), 0);
    check_cursor("mrst_cur", 0, 0);
    rst = 1'b0;
    tick();
    check("post_rst_wen", 32'(wen_o), 0);
    send(8'h61);
    check("a_wen", 32'(wen_o), 1);
    check("a_addr", 32'(addr_o), 0);
    send(8'h07);
    check("bel_wen", 32'(wen_o), 0);
    check_cursor("bel_cur", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
